// File: rtl/c2h_multiflow_gen.sv
// c2h_multiflow_gen: credit-gated, round-robin packet generator for NUM_FLOWS
// flows driving the QDMA C2H AXI-Stream slave directly (no FIFO).
// Ports:
//   axi_aclk/axi_aresetn      clock, async active-low reset
//   control_reg               bit1 rising edge = start, bit2 level = stop
//   txr_size/num_pkt/flow_en  run configuration, sampled at start
//   credit_in/flow/updt       per-flow credit add strobe (saturating)
//   c2h_t*                    AXI-Stream master, c2h_tid = flow index
//   c2h_end                   one-cycle run-complete pulse
//   busy                      high whenever the FSM is not IDLE
module c2h_multiflow_gen #(
    parameter int unsigned C_DATA_WIDTH = 512,
    parameter int unsigned TM_DSC_BITS  = 16,
    parameter int unsigned NUM_FLOWS    = 4,
    parameter int unsigned FID_W        = $clog2(NUM_FLOWS)
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [31:0]               control_reg,
    input  logic [15:0]               txr_size,
    input  logic [10:0]               num_pkt,
    input  logic [NUM_FLOWS-1:0]      flow_en,
    input  logic [TM_DSC_BITS-1:0]    credit_in,
    input  logic [FID_W-1:0]          credit_flow,
    input  logic                      credit_updt,
    output logic [C_DATA_WIDTH-1:0]   c2h_tdata,
    output logic [C_DATA_WIDTH/8-1:0] c2h_tkeep,
    output logic [FID_W-1:0]          c2h_tid,
    output logic                      c2h_tvalid,
    output logic                      c2h_tlast,
    input  logic                      c2h_tready,
    output logic                      c2h_end,
    output logic                      busy
);

    localparam int unsigned BYTES  = C_DATA_WIDTH / 8;
    localparam int unsigned LANES  = C_DATA_WIDTH / 32;
    localparam int unsigned BEAT_W = 16;
    localparam int unsigned CNT_W  = 11;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND, S_DONE} state_e;

    state_e                   state_q, state_d;
    logic                     start_prev_q, start_prev_d;
    logic [BEAT_W-1:0]        beats_q, beats_d;
    logic [BYTES-1:0]         last_keep_q, last_keep_d;
    logic [CNT_W-1:0]         rem_q [NUM_FLOWS];
    logic [CNT_W-1:0]         rem_d [NUM_FLOWS];
    logic [CNT_W-1:0]         seq_q [NUM_FLOWS];
    logic [CNT_W-1:0]         seq_d [NUM_FLOWS];
    logic [TM_DSC_BITS-1:0]   credit_q [NUM_FLOWS];
    logic [TM_DSC_BITS-1:0]   credit_d [NUM_FLOWS];
    logic [TM_DSC_BITS:0]     cred_sum [NUM_FLOWS];
    logic [FID_W-1:0]         rr_q, rr_d;
    logic [FID_W-1:0]         cur_q, cur_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [BEAT_W-1:0]        nxt_beat;
    logic [C_DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [BYTES-1:0]         tkeep_q, tkeep_d;
    logic [FID_W-1:0]         tid_q, tid_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;
    logic                     end_q, end_d;
    logic                     busy_q, busy_d;

    logic                     start_c;
    logic                     stop_c;
    logic                     gnt_vld;
    logic [FID_W-1:0]         gnt_idx;
    logic                     any_rem;
    logic                     unused_ctrl;

    assign start_c     = control_reg[1] & ~start_prev_q;
    assign stop_c      = control_reg[2];
    assign nxt_beat    = beat_q + BEAT_W'(1);
    assign unused_ctrl = ^{control_reg[31:3], control_reg[0]};

    // Every 32-bit lane carries {flow, beat index, 5'b0, sequence}.
    function automatic logic [C_DATA_WIDTH-1:0] build_beat(input logic [FID_W-1:0] f,
                                                            input logic [7:0]       b,
                                                            input logic [CNT_W-1:0] s);
        logic [C_DATA_WIDTH-1:0] r;
        r = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            r[l*32 +: 32] = {8'(f), b, 5'b0, s};
        end
        return r;
    endfunction

    // Saturating credit add per flow.
    always_comb begin
        for (int f = 0; f < NUM_FLOWS; f++) begin
            cred_sum[f] = {1'b0, credit_q[f]} + {1'b0, credit_in};
        end
    end

    // Round-robin search: lowest offset from rr_q wins, so scan offsets downward.
    always_comb begin
        logic [FID_W-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        any_rem = 1'b0;
        for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
            cand = FID_W'((int'(rr_q) + i) % NUM_FLOWS);
            if (rem_q[cand] != '0 && credit_q[cand] != '0) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (rem_q[f] != '0) any_rem = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        int unsigned keep_rem;
        state_d      = state_q;
        start_prev_d = control_reg[1];
        beats_d      = beats_q;
        last_keep_d  = last_keep_q;
        rem_d        = rem_q;
        seq_d        = seq_q;
        rr_d         = rr_q;
        cur_d        = cur_q;
        beat_d       = beat_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tid_d        = tid_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        end_d        = 1'b0;
        keep_rem     = 32'(txr_size) % BYTES;

        // Credit adds apply in every state; the grant decrement below stacks on top.
        for (int f = 0; f < NUM_FLOWS; f++) begin
            credit_d[f] = credit_q[f];
            if (credit_updt && credit_flow == FID_W'(f)) begin
                credit_d[f] = cred_sum[f][TM_DSC_BITS] ? '1 : cred_sum[f][TM_DSC_BITS-1:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_c && txr_size != '0 && num_pkt != '0 && flow_en != '0) begin
                    beats_d = BEAT_W'((32'(txr_size) + BYTES - 1) / BYTES);
                    for (int unsigned i = 0; i < BYTES; i++) begin
                        last_keep_d[i] = (keep_rem == 0) || (i < keep_rem);
                    end
                    for (int f = 0; f < NUM_FLOWS; f++) begin
                        rem_d[f] = flow_en[f] ? num_pkt : '0;
                        seq_d[f] = '0;
                    end
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (stop_c) begin
                    state_d = S_IDLE;
                end else if (gnt_vld) begin
                    credit_d[gnt_idx] = credit_d[gnt_idx] - TM_DSC_BITS'(1);
                    cur_d    = gnt_idx;
                    beat_d   = '0;
                    tvalid_d = 1'b1;
                    tid_d    = gnt_idx;
                    tdata_d  = build_beat(gnt_idx, 8'd0, seq_q[gnt_idx]);
                    tlast_d  = (beats_q == BEAT_W'(1));
                    tkeep_d  = tlast_d ? last_keep_q : '1;
                    state_d  = S_SEND;
                end else if (!any_rem) begin
                    end_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_SEND: begin
                if (tvalid_q && c2h_tready) begin
                    if (tlast_q) begin
                        tvalid_d     = 1'b0;
                        tlast_d      = 1'b0;
                        tkeep_d      = '0;
                        tdata_d      = '0;
                        rem_d[cur_q] = rem_q[cur_q] - CNT_W'(1);
                        seq_d[cur_q] = seq_q[cur_q] + CNT_W'(1);
                        rr_d         = (cur_q == FID_W'(NUM_FLOWS - 1)) ? '0 : cur_q + FID_W'(1);
                        state_d      = S_ARB;
                    end else begin
                        beat_d  = nxt_beat;
                        tdata_d = build_beat(cur_q, 8'(nxt_beat), seq_q[cur_q]);
                        tlast_d = (nxt_beat == beats_q - BEAT_W'(1));
                        tkeep_d = tlast_d ? last_keep_q : '1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            beats_q      <= '0;
            last_keep_q  <= '0;
            for (int f = 0; f < NUM_FLOWS; f++) begin
                rem_q[f]    <= '0;
                seq_q[f]    <= '0;
                credit_q[f] <= '0;
            end
            rr_q     <= '0;
            cur_q    <= '0;
            beat_q   <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tid_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            end_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            beats_q      <= beats_d;
            last_keep_q  <= last_keep_d;
            rem_q        <= rem_d;
            seq_q        <= seq_d;
            credit_q     <= credit_d;
            rr_q         <= rr_d;
            cur_q        <= cur_d;
            beat_q       <= beat_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tid_q        <= tid_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            end_q        <= end_d;
            busy_q       <= busy_d;
        end
    end

    assign c2h_tdata  = tdata_q;
    assign c2h_tkeep  = tkeep_q;
    assign c2h_tid    = tid_q;
    assign c2h_tvalid = tvalid_q;
    assign c2h_tlast  = tlast_q;
    assign c2h_end    = end_q;
    assign busy       = busy_q;

endmodule

// File: doc/c2h_multiflow_gen.md
Name: c2h_multiflow_gen

Overview:
- Parametrised successor to the single-flow C2H traffic path.
- Generates credit-gated packet traffic for NUM_FLOWS independent flows toward the QDMA C2H AXI-Stream port.
- Arbitrates round-robin per packet and tags each packet with its flow index on c2h_tid.
- Drives the QDMA C2H slave directly, with no intermediate FIFO.

Parameters:
- C_DATA_WIDTH, 512: stream data width in bits, multiple of 32; BYTES = C_DATA_WIDTH/8.
- TM_DSC_BITS, 16: width of the credit counters and of credit_in.
- NUM_FLOWS, 4: number of flows, 2..16.
- FID_W, $clog2(NUM_FLOWS): flow index width (derived).

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- control_reg  in  32  bit1 rising edge = start; bit2 level = stop request.
- txr_size  in  16  packet length in bytes, all flows.
- num_pkt  in  11  packets per enabled flow per run.
- flow_en  in  NUM_FLOWS  per-flow enable, sampled at start.
- credit_in  in  TM_DSC_BITS  credits to add.
- credit_flow  in  FID_W  target flow for credit_in.
- credit_updt  in  1  credit add strobe.
- c2h_tdata  out  C_DATA_WIDTH  payload.
- c2h_tkeep  out  BYTES  byte enables.
- c2h_tid  out  FID_W  flow index of the current packet.
- c2h_tvalid  out  1  beat valid.
- c2h_tlast  out  1  last beat of the packet.
- c2h_tready  in  1  sink ready.
- c2h_end  out  1  single-cycle run-complete pulse.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FSM in IDLE.
  - Credit counters, remaining-packet counters, sequence counters and the round-robin pointer all 0.
- Start:
  - Start = rising edge of control_reg[1], detected with a registered previous value.
  - Honoured only in IDLE, with txr_size != 0, num_pkt != 0 and flow_en != 0; otherwise ignored.
  - On an honoured start: latch flow_en, txr_size and num_pkt; set remaining[f] = num_pkt for enabled flows and 0 otherwise; clear seq[f]; go to ARB next cycle.
- Beat count:
  - beats = ceil(txr_size/BYTES), computed at start.
  - last_keep = low (txr_size mod BYTES) bits set, or all ones if the remainder is 0.
- FSM:
  - IDLE: wait for an honoured start.
  - ARB: eligible[f] = remaining[f] != 0 && credit[f] != 0.
    - Grant the first eligible flow at or after rr_ptr, wrapping.
    - On grant: credit[f] -= 1; go to SEND; first beat valid on the next cycle.
    - None eligible but some remaining != 0: stay in ARB (credit stall).
    - All remaining == 0: go to DONE.
    - Stop asserted: go to IDLE with no c2h_end.
  - SEND: emit beats. A beat transfers when c2h_tvalid && c2h_tready.
    - tdata, tkeep, tid and tlast are held stable while tvalid && !tready.
    - On the last-beat transfer: remaining[f] -= 1; seq[f] += 1 (11-bit wrap); rr_ptr = f+1 mod NUM_FLOWS; go to ARB.
    - Stop is ignored mid-packet and takes effect in ARB.
  - DONE: c2h_end = 1 for exactly one cycle; return to IDLE.
- Beat payload:
  - Every 32-bit lane = {8'(flow), 8'(beat_idx), 5'b0, seq[10:0]}.
  - tkeep is all ones except on the last beat, where it equals last_keep.
  - tlast = 1 only on the last beat.
  - Back-to-back packets are separated by exactly one idle cycle (ARB).
- Credits:
  - credit_updt adds credit_in to credit[credit_flow] in any state, including IDLE.
  - Add saturates at 2^TM_DSC_BITS-1.
  - An add and a grant decrement on the same flow in the same cycle apply both: new = sat(old + credit_in) - 1.
  - credit_flow >= NUM_FLOWS: update is dropped.
  - Credits persist across runs; only reset clears them.
- Reset mid-packet: all outputs drop to 0 immediately. No partial-packet recovery is required.

Test Plan:
- NUM_FLOWS=4, flow_en=4'b0001, txr_size=128, num_pkt=3, credit[0]=3 then start -> 3 packets of 2 beats, all tkeep all ones, tid=0, seq 0,1,2, then c2h_end pulse one cycle after the final tlast.
- flow_en=4'b1111, credits 2 each, num_pkt=2, txr_size=64 -> packet tid order 0,1,2,3,0,1,2,3; one beat each; c2h_end asserted once.
- txr_size=100, C_DATA_WIDTH=512 -> 2 beats; last tkeep=64'h0000_000F_FFFF_FFFF.
- Flow 1 at 0 credits, flow 0 at 5, both enabled, num_pkt=2 -> only tid 0 sent and FSM stalls in ARB; credit_updt of 2 to flow 1 -> flow 1 packets follow and c2h_end fires.
- tready toggled 1010... during a 4-beat packet -> tdata/tkeep/tid stable while stalled; beat_idx sequence 0,1,2,3 with no repeats or skips.
- credit[2]=16'hFFFE, credit_updt with credit_in=5 in the same cycle as flow 2's grant -> credit[2]=16'hFFFE. Stop asserted mid-packet -> packet completes, FSM returns to IDLE, and no c2h_end pulse occurs.
